uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx transmitter (9600 baud at 50 MHz, 5208 clk/bit) between N_REQ byte sources.

---
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between N_REQ byte sources. Round-robin arbitration
// happens per message. A granted requester keeps the transmitter until it sends a byte
// flagged last.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a grant is revoked after
// TIMEOUT_CYC idle cycles in LOAD.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 52080
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       grant_act,
  output logic                       timeout_p
);

  localparam int unsigned GW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 2");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StStart, StWait} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic          grant_act_q, grant_act_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          last_q, last_d;

  logic          xfer;
  logic          timeout_fire;
  logic [GW-1:0] pick_idx;
  logic          pick_found;
  logic [GW:0]   cand;

  // Byte handshake with the granted requester; kept independent of the timeout logic.
  assign xfer = (state_q == StLoad) && req_valid[grant_id_q] && !tx_busy;

  // Round-robin scan starting just after the last owner.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      cand = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(N_REQ)) begin
        cand = cand - (GW+1)'(N_REQ);
      end
      if (!pick_found && req_valid[cand[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[GW-1:0];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_p_q, timeout_p_d;

  // Count cycles in which the owner has nothing to offer; any transfer restarts the count.
  always_comb begin
    to_cnt_d     = to_cnt_q;
    timeout_fire = 1'b0;
    if (state_q == StLoad) begin
      if (xfer) begin
        to_cnt_d = '0;
      end else if (!req_valid[grant_id_q]) begin
        if (to_cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          timeout_fire = 1'b1;
          to_cnt_d     = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
    end
    timeout_p_d = timeout_fire;
  end

  // Timeout counter and pulse registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_cnt_q    <= '0;
      timeout_p_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      timeout_p_q <= timeout_p_d;
    end
  end

  assign timeout_p = timeout_p_q;
`else
  assign timeout_fire = 1'b0;
  assign timeout_p    = 1'b0;
`endif

  // Next-state logic and the combinational ready decode.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    grant_act_d = grant_act_q;
    tx_data_d   = tx_data_q;
    last_d      = last_q;
    req_ready   = '0;
    unique case (state_q)
      StIdle: begin
        // tx_busy is deliberately ignored here; it only gates the byte handshake.
        if (pick_found) begin
          grant_id_d  = pick_idx;
          grant_act_d = 1'b1;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        req_ready[grant_id_q] = !tx_busy;
        if (xfer) begin
          tx_data_d = req_data[{grant_id_q, 3'b000} +: 8];
          last_d    = req_last[grant_id_q];
          state_d   = StStart;
        end else if (timeout_fire) begin
          rr_ptr_d    = grant_id_q;
          grant_act_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        if (!tx_busy) begin
          if (last_q) begin
            rr_ptr_d    = grant_id_q;
            grant_act_d = 1'b0;
            state_d     = StIdle;
          end else begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= GW'(N_REQ - 1);
      grant_id_q  <= '0;
      grant_act_q <= 1'b0;
      tx_data_q   <= 8'h00;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      grant_act_q <= grant_act_d;
      tx_data_q   <= tx_data_d;
      last_q      <= last_d;
    end
  end

  assign tx_start  = (state_q == StStart);
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign grant_act = grant_act_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. Per-requester byte queues drive the inputs. Expected
// (grant_id, byte) pairs are queued when stimulus is issued, and a monitor pops them
// on every tx_start. A short behavioural uart_tx stands in for the real transmitter.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int BUSY = 40;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 52080;
`endif

  logic           sys_clk = 1'b0;
  logic           sys_rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           grant_act;
  logic           timeout_p;

  int total = 0;
  int bad   = 0;

  logic [8:0]  rq [N][$];  // {last, data}
  logic [15:0] sbq[$];     // {grant_id, data}

  uart_tx_arbiter #(
    .N_REQ      (N),
    .TIMEOUT_CYC(TO)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .grant_act(grant_act),
    .timeout_p(timeout_p)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    v = '0;
    l = '0;
    d = {N{8'hEE}};
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        v[k]         = 1'b1;
        l[k]         = rq[k][0][8];
        d[8*k +: 8]  = rq[k][0][7:0];
      end
    end
    req_valid = v;
    req_last  = l;
    req_data  = d;
  endtask

  // Requester model: pop a byte after each handshake seen at the previous negedge.
  initial begin : driver
    logic [N-1:0] hs;
    forever begin
      @(negedge sys_clk);
      hs = sys_rst_n ? (req_valid & req_ready) : '0;
      @(posedge sys_clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (hs[k] && rq[k].size() > 0) void'(rq[k].pop_front());
      end
      drive();
    end
  end

  // Behavioural uart_tx: busy from the cycle after tx_start for BUSY cycles.
  initial begin : busy_model
    tx_busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (tx_start) begin
        @(posedge sys_clk);
        #1 tx_busy = 1'b1;
        repeat (BUSY - 1) @(posedge sys_clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pop on tx_start, latency and handshake sanity.
  initial begin : monitor
    logic        prev_start;
    logic        pend;
    logic [7:0]  pend_data;
    logic [15:0] e;
    logic [N-1:0] hs;
    prev_start = 1'b0;
    pend       = 1'b0;
    pend_data  = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        prev_start = 1'b0;
        pend       = 1'b0;
      end else begin
        if (pend) begin
          check("latency_tx_start", 32'(tx_start), 32'd1);
          check("latency_tx_data", 32'(tx_data), 32'(pend_data));
          pend = 1'b0;
        end
        if (tx_start) begin
          check("tx_start_one_cycle", 32'(prev_start), 32'd0);
          check("grant_act_at_start", 32'(grant_act), 32'd1);
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_tx_start: got data %0h grant %0d expected none at %0t",
                     tx_data, grant_id, $time);
          end else begin
            e = sbq.pop_front();
            check("tx_data", 32'(tx_data), 32'(e[7:0]));
            check("grant_id", 32'(grant_id), 32'(e[15:8]));
          end
        end
        if (req_ready != '0) begin
          check("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
          check("req_ready_not_busy", 32'(tx_busy), 32'd0);
        end
        hs = req_valid & req_ready;
        for (int k = 0; k < N; k++) begin
          if (hs[k]) begin
            pend      = 1'b1;
            pend_data = req_data[8*k +: 8];
          end
        end
        prev_start = tx_start;
      end
    end
  end

  task automatic push_exp(input int gid, input logic [7:0] d);
    sbq.push_back({8'(gid), d});
  endtask

  task automatic do_reset();
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #2;
    check("rst_grant_act", 32'(grant_act), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_timeout_p", 32'(timeout_p), 32'd0);
    for (int k = 0; k < N; k++) rq[k].delete();
    sbq.delete();
    drive();
    repeat (2) @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge sys_clk);
      if (sbq.size() == 0 && rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
          rq[3].size() == 0 && !grant_act && !tx_busy) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: got pending=%0d expected 0 within %0d cycles",
               name, sbq.size(), budget);
    end
  endtask

  initial begin : main
    sys_rst_n = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    repeat (3) @(posedge sys_clk);
    do_reset();

    // Reset while a multi-byte message is in WAIT.
    rq[0].push_back({1'b0, 8'h11});
    rq[0].push_back({1'b0, 8'h22});
    rq[0].push_back({1'b1, 8'h33});
    push_exp(0, 8'h11);
    drive();
    for (int c = 0; c < 50 && !tx_busy; c++) @(negedge sys_clk);
    check("t1_reached_wait", 32'(tx_busy), 32'd1);
    repeat (5) @(posedge sys_clk);
    do_reset();
    repeat (10) @(negedge sys_clk);
    check("t1_idle_after_reset", 32'(grant_act), 32'd0);

    // Single requester, three-byte message.
    rq[0].push_back({1'b0, 8'h55});
    rq[0].push_back({1'b0, 8'hAA});
    rq[0].push_back({1'b1, 8'h0F});
    push_exp(0, 8'h55);
    push_exp(0, 8'hAA);
    push_exp(0, 8'h0F);
    drive();
    wait_idle("t2", 2000);
    check("t2_grant_act_released", 32'(grant_act), 32'd0);

    // Two requesters from reset: whole message of 0, then whole message of 2.
    do_reset();
    rq[0].push_back({1'b0, 8'hA1});
    rq[0].push_back({1'b1, 8'hA2});
    rq[2].push_back({1'b0, 8'hC1});
    rq[2].push_back({1'b1, 8'hC2});
    push_exp(0, 8'hA1);
    push_exp(0, 8'hA2);
    push_exp(2, 8'hC1);
    push_exp(2, 8'hC2);
    drive();
    wait_idle("t3", 2000);

    // All four requesters with single-byte messages: order 0,1,2,3,0.
    do_reset();
    rq[0].push_back({1'b1, 8'h40});
    rq[0].push_back({1'b1, 8'h44});
    rq[1].push_back({1'b1, 8'h41});
    rq[2].push_back({1'b1, 8'h42});
    rq[3].push_back({1'b1, 8'h43});
    push_exp(0, 8'h40);
    push_exp(1, 8'h41);
    push_exp(2, 8'h42);
    push_exp(3, 8'h43);
    push_exp(0, 8'h44);
    drive();
    wait_idle("t4", 3000);

    // Requester 1 stalls mid-message while requester 3 waits.
    do_reset();
    rq[1].push_back({1'b0, 8'h31});
    rq[3].push_back({1'b1, 8'h77});
    push_exp(1, 8'h31);
    drive();
`ifdef ARB_TIMEOUT_EN
    push_exp(3, 8'h77);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
        @(negedge sys_clk);
        if (timeout_p) seen = 1'b1;
      end
      check("t5_timeout_seen", 32'(seen), 32'd1);
      @(negedge sys_clk);
      check("t5_timeout_one_cycle", 32'(timeout_p), 32'd0);
    end
    wait_idle("t5", 2000);
`else
    repeat (300) @(negedge sys_clk);
    check("t5_grant_held_act", 32'(grant_act), 32'd1);
    check("t5_grant_held_id", 32'(grant_id), 32'd1);
    check("t5_req3_pending", 32'(rq[3].size()), 32'd1);
    check("t5_no_timeout", 32'(timeout_p), 32'd0);
    check("t5_sb_drained", 32'(sbq.size()), 32'd0);
`endif

    repeat (5) @(negedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
